sys_mng_drp_resp: RTL and testbench
===================================

SYS_MNG_DRP_RESP -- requirements
Module: sys_mng_drp_resp

Interface
REQ-001 Parameter RDY_LATENCY, default 2, cycles from accepted DRP_EN to DRP_RDY; legal range 1..15.
REQ-002 CLK  input  1  single clock; all logic rising-edge.
REQ-003 RESETN  input  1  reset, asynchronous assert, active-low.
REQ-004 DRP_ADDR  input  8  DRP register address, sampled with DRP_EN.
REQ-005 DRP_DI  input  16  DRP write data, sampled with DRP_EN.
REQ-006 DRP_EN  input  1  one-cycle request strobe.
REQ-007 DRP_WE  input  1  write qualifier, sampled with DRP_EN.
REQ-008 DRP_DO  output  16  read data, valid only while DRP_RDY=1.
REQ-009 DRP_RDY  output  1  one-cycle completion strobe.
REQ-010 SAMPLE_VALID  input  1  new sensor sample strobe.
REQ-011 SAMPLE_CH  input  2  channel: 0 temp, 1 vccint, 2 vccaux, 3 vccbram.
REQ-012 SAMPLE_DATA  input  16  sample value, unsigned.
REQ-013 PROTO_ERR  output  1  sticky flag: DRP_EN received while busy.

Function
REQ-014 The block SHALL be a DRP responder emulating the system-monitor status map: current 0x00 temp, 0x01 vccint, 0x02 vccaux, 0x06 vccbram; max 0x20..0x23; min 0x24..0x27 (channel order as SAMPLE_CH).
REQ-015 Config registers 0x40, 0x41, 0x42 SHALL be read/write scratch, 16 bits each.
REQ-016 Reads of unmapped addresses SHALL return 0x0000; writes to unmapped or status addresses SHALL be ignored, except REQ-022.
REQ-017 FSM states SHALL be IDLE and BUSY; IDLE + DRP_EN -> BUSY, latching ADDR/WE/DI and loading a latency counter.
REQ-018 In BUSY, DRP_RDY SHALL assert for exactly one cycle, RDY_LATENCY cycles after the DRP_EN cycle; FSM returns to IDLE in that cycle.
REQ-019 DRP_EN coincident with the DRP_RDY cycle SHALL be accepted as a new request (back-to-back); the next RDY follows RDY_LATENCY cycles later.
REQ-020 DRP_EN in BUSY before the RDY cycle SHALL be ignored and SHALL set PROTO_ERR, which holds until reset.
REQ-021 Read data SHALL be the register's registered value at the RDY cycle; DRP_DO SHALL be 0x0000 whenever DRP_RDY=0.
REQ-022 A write to 0x03 with DI[0]=1 SHALL, in the RDY cycle, reset all max to 0x0000 and all min to 0xFFFF; DI[0]=0 has no effect.
REQ-023 Writes SHALL take effect in the RDY cycle (visible from the next cycle).
REQ-024 On SAMPLE_VALID: current[ch] <= data; max[ch] <= data if data > max[ch]; min[ch] <= data if data < min[ch]; unsigned compare.
REQ-025 A sample and a read of the same register in the same cycle SHALL return the pre-update value.
REQ-026 A sample coincident with a min/max clear SHALL result in the clear values for that channel (clear wins); current[ch] still updates.

Reset
REQ-027 While RESETN=0: FSM IDLE, counter 0, DRP_RDY 0, DRP_DO 0x0000, PROTO_ERR 0, current regs 0x0000, max 0x0000, min 0xFFFF, config 0x0000.
REQ-028 Reset mid-transaction SHALL abort it with no DRP_RDY and no write committed; first request after RESETN rises SHALL be accepted normally.

Verification
REQ-029 RDY_LATENCY=2; SAMPLE ch0=0x1234, then read 0x00, 0x20, 0x24 -> each RDY exactly 2 cycles after EN, DO 0x1234 for all three.
REQ-030 Samples ch1 0x0500, 0x0300, 0x0800 -> reads 0x01=0x0800, 0x21=0x0800, 0x25=0x0300; write 0x03 DI=0x0001 -> 0x21=0x0000, 0x25=0xFFFF.
REQ-031 Write 0x41=0xBEEF, read 0x41 -> 0xBEEF; write 0x00=0xAAAA -> 0x00 unchanged; read 0x10 -> 0x0000.
REQ-032 EN at cycle t and t+1 (latency 3) -> single RDY at t+3, PROTO_ERR=1 from t+2; EN in RDY cycle -> second RDY at t+6, PROTO_ERR unchanged.
REQ-033 RESETN low one cycle after EN of a write to 0x40=0x5555 -> no RDY, 0x40 reads 0x0000 after reset; all outputs at REQ-027 values during reset.
REQ-034 Sweep RDY_LATENCY 1 and 15 with random back-to-back reads against a reference model -> RDY timing and DO match every transaction.

Source files
------------

// File: rtl/sys_mng_drp_resp.sv
// DRP responder emulating the system-monitor status register map.
// Holds current/max/min sensor values per channel plus three scratch
// config registers; answers each DRP request RDY_LATENCY cycles later.
module sys_mng_drp_resp #(
   parameter int RDY_LATENCY = 2
) (
   input  logic        CLK,
   input  logic        RESETN,
   input  logic [7:0]  DRP_ADDR,
   input  logic [15:0] DRP_DI,
   input  logic        DRP_EN,
   input  logic        DRP_WE,
   output logic [15:0] DRP_DO,
   output logic        DRP_RDY,
   input  logic        SAMPLE_VALID,
   input  logic [1:0]  SAMPLE_CH,
   input  logic [15:0] SAMPLE_DATA,
   output logic        PROTO_ERR
);

   // Counter reloads with latency-1 so RDY lands RDY_LATENCY cycles after EN.
   localparam logic [3:0] CNT_LOAD = 4'(RDY_LATENCY - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  addr_q, addr_d;
   logic        we_q, we_d;
   logic [15:0] di_q, di_d;
   logic        perr_q, perr_d;

   logic [15:0] cur_q [4];
   logic [15:0] cur_d [4];
   logic [15:0] max_q [4];
   logic [15:0] max_d [4];
   logic [15:0] min_q [4];
   logic [15:0] min_d [4];
   logic [15:0] cfg_q [3];
   logic [15:0] cfg_d [3];

   logic        rdy;
   logic        accept;
   logic        wr;
   logic        clr;
   logic [15:0] rd_data;

   // Request FSM: accept in IDLE or in the RDY cycle, flag EN while still counting.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      di_d    = di_q;
      perr_d  = perr_q;
      rdy     = 1'b0;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (DRP_EN) accept = 1'b1;
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               rdy     = 1'b1;
               state_d = IDLE;
               if (DRP_EN) accept = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (DRP_EN) perr_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         state_d = BUSY;
         cnt_d   = CNT_LOAD;
         addr_d  = DRP_ADDR;
         we_d    = DRP_WE;
         di_d    = DRP_DI;
      end
   end

   assign wr  = rdy && we_q;
   assign clr = wr && (addr_q == 8'h03) && di_q[0];

   // Read mux over the registered values; sees pre-update state in the RDY cycle.
   always_comb begin
      rd_data = 16'h0000;
      case (addr_q)
         8'h00:                      rd_data = cur_q[0];
         8'h01:                      rd_data = cur_q[1];
         8'h02:                      rd_data = cur_q[2];
         8'h06:                      rd_data = cur_q[3];
         8'h20, 8'h21, 8'h22, 8'h23: rd_data = max_q[addr_q[1:0]];
         8'h24, 8'h25, 8'h26, 8'h27: rd_data = min_q[addr_q[1:0]];
         8'h40:                      rd_data = cfg_q[0];
         8'h41:                      rd_data = cfg_q[1];
         8'h42:                      rd_data = cfg_q[2];
         default:                    rd_data = 16'h0000;
      endcase
   end

   // DO carries read data only in a read's RDY cycle, zero otherwise.
   assign DRP_DO    = (rdy && !we_q) ? rd_data : 16'h0000;
   assign DRP_RDY   = rdy;
   assign PROTO_ERR = perr_q;

   // Sensor tracking and register writes; a min/max clear overrides a same-cycle sample.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cur_d[i] = cur_q[i];
         max_d[i] = max_q[i];
         min_d[i] = min_q[i];
      end
      for (int i = 0; i < 3; i++) cfg_d[i] = cfg_q[i];
      if (SAMPLE_VALID) begin
         cur_d[SAMPLE_CH] = SAMPLE_DATA;
         if (SAMPLE_DATA > max_q[SAMPLE_CH]) max_d[SAMPLE_CH] = SAMPLE_DATA;
         if (SAMPLE_DATA < min_q[SAMPLE_CH]) min_d[SAMPLE_CH] = SAMPLE_DATA;
      end
      if (clr) begin
         for (int i = 0; i < 4; i++) begin
            max_d[i] = 16'h0000;
            min_d[i] = 16'hFFFF;
         end
      end
      if (wr) begin
         case (addr_q)
            8'h40:   cfg_d[0] = di_q;
            8'h41:   cfg_d[1] = di_q;
            8'h42:   cfg_d[2] = di_q;
            default: ;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 8'h00;
         we_q    <= 1'b0;
         di_q    <= 16'h0000;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         di_q    <= di_d;
         perr_q  <= perr_d;
      end
   end

   // Status and config register file.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         for (int i = 0; i < 4; i++) begin
            cur_q[i] <= 16'h0000;
            max_q[i] <= 16'h0000;
            min_q[i] <= 16'hFFFF;
         end
         for (int i = 0; i < 3; i++) cfg_q[i] <= 16'h0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            cur_q[i] <= cur_d[i];
            max_q[i] <= max_d[i];
            min_q[i] <= min_d[i];
         end
         for (int i = 0; i < 3; i++) cfg_q[i] <= cfg_d[i];
      end
   end

endmodule

// File: tb/tb_sys_mng_drp_resp.sv
// Bench: four responders (latency 2, 3, 1, 15) share one stimulus stream.
// A transaction-level model (due-cycle bookkeeping, plain register arrays)
// checks every instance every cycle; directed tables and sequences cover
// the documented scenarios.
module tb_sys_mng_drp_resp;

   localparam int ND = 4;

   function automatic int lat_of(input int k);
      case (k)
         0:       return 2;
         1:       return 3;
         2:       return 1;
         default: return 15;
      endcase
   endfunction

   logic        clk;
   logic        rst_n;
   logic [7:0]  addr;
   logic [15:0] di;
   logic        en;
   logic        we;
   logic        sv;
   logic [1:0]  sch;
   logic [15:0] sdata;
   logic [15:0] do_w   [ND];
   logic        rdy_w  [ND];
   logic        perr_w [ND];

   for (genvar g = 0; g < ND; g++) begin : g_dut
      sys_mng_drp_resp #(.RDY_LATENCY(lat_of(g))) u_dut (
         .CLK          (clk),
         .RESETN       (rst_n),
         .DRP_ADDR     (addr),
         .DRP_DI       (di),
         .DRP_EN       (en),
         .DRP_WE       (we),
         .DRP_DO       (do_w[g]),
         .DRP_RDY      (rdy_w[g]),
         .SAMPLE_VALID (sv),
         .SAMPLE_CH    (sch),
         .SAMPLE_DATA  (sdata),
         .PROTO_ERR    (perr_w[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;
   int cyc;

   // Reference model state, one copy per instance.
   bit          m_busy [ND];
   int          m_due  [ND];
   logic [7:0]  m_addr [ND];
   logic        m_we   [ND];
   logic [15:0] m_di   [ND];
   bit          m_perr [ND];
   logic [15:0] m_cur  [ND][4];
   logic [15:0] m_max  [ND][4];
   logic [15:0] m_min  [ND][4];
   logic [15:0] m_cfg  [ND][3];

   typedef struct {
      bit          smp;
      logic [7:0]  a;
      bit          w;
      logic [15:0] d;
      logic [15:0] exp;
   } vec_t;

   localparam logic [7:0] ADDRS [19] = '{8'h00, 8'h01, 8'h02, 8'h06, 8'h20, 8'h21, 8'h22,
                                         8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h40, 8'h41,
                                         8'h42, 8'h03, 8'h10, 8'hFF, 8'h05};

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad < 60) $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, act, exp);
      end
   endtask

   function automatic logic [15:0] m_read(input int k, input logic [7:0] a);
      int ai;
      ai = int'(a);
      if (ai <= 2)               return m_cur[k][ai];
      if (ai == 6)               return m_cur[k][3];
      if (ai >= 32 && ai <= 35)  return m_max[k][ai - 32];
      if (ai >= 36 && ai <= 39)  return m_min[k][ai - 36];
      if (ai >= 64 && ai <= 66)  return m_cfg[k][ai - 64];
      return 16'h0000;
   endfunction

   // Compare this cycle's outputs with the model, then advance it past the next edge.
   task automatic model_step();
      bit          r;
      logic [15:0] ex;
      for (int k = 0; k < ND; k++) begin
         if (!rst_n) begin
            m_busy[k] = 0; m_due[k] = 0; m_addr[k] = 0; m_we[k] = 0; m_di[k] = 0; m_perr[k] = 0;
            for (int c = 0; c < 4; c++) begin
               m_cur[k][c] = 16'h0000; m_max[k][c] = 16'h0000; m_min[k][c] = 16'hFFFF;
            end
            for (int c = 0; c < 3; c++) m_cfg[k][c] = 16'h0000;
            chk("rst_rdy", k, 32'(rdy_w[k]), 0);
            chk("rst_do", k, 32'(do_w[k]), 0);
            chk("rst_perr", k, 32'(perr_w[k]), 0);
         end else begin
            r  = m_busy[k] && (m_due[k] == cyc);
            ex = (r && !m_we[k]) ? m_read(k, m_addr[k]) : 16'h0000;
            chk("rdy", k, 32'(rdy_w[k]), 32'(r));
            if (!(r && m_we[k])) chk("do", k, 32'(do_w[k]), 32'(ex));
            chk("perr", k, 32'(perr_w[k]), 32'(m_perr[k]));
            if (sv) begin
               m_cur[k][sch] = sdata;
               if (sdata > m_max[k][sch]) m_max[k][sch] = sdata;
               if (sdata < m_min[k][sch]) m_min[k][sch] = sdata;
            end
            if (r && m_we[k]) begin
               if (m_addr[k] == 8'h03 && m_di[k][0])
                  for (int c = 0; c < 4; c++) begin
                     m_max[k][c] = 16'h0000; m_min[k][c] = 16'hFFFF;
                  end
               if (m_addr[k] >= 8'h40 && m_addr[k] <= 8'h42)
                  m_cfg[k][int'(m_addr[k]) - 64] = m_di[k];
            end
            if (r) m_busy[k] = 0;
            if (en) begin
               if (!m_busy[k]) begin
                  m_busy[k] = 1; m_due[k] = cyc + lat_of(k);
                  m_addr[k] = addr; m_we[k] = we; m_di[k] = di;
               end else begin
                  m_perr[k] = 1;
               end
            end
         end
      end
      cyc++;
   endtask

   task automatic mid();
      @(negedge clk);
      model_step();
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         mid(); to_next();
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
   endtask

   // One DRP transaction timed on the latency-2 instance.
   task automatic drp_op(input vec_t v);
      bit got;
      en = 1'b1; we = v.w; addr = v.a; di = v.d;
      mid(); to_next();
      en = 1'b0; we = 1'b0;
      got = 0;
      for (int n = 1; n <= 20 && !got; n++) begin
         mid();
         if (rdy_w[0]) begin
            got = 1;
            chk("latency", 0, 32'(n), 2);
            if (!v.w) chk("rd_data", 0, 32'(do_w[0]), 32'(v.exp));
         end
         to_next();
      end
      if (!got) chk("rdy_timeout", 0, 0, 1);
      idle(2);
   endtask

   task automatic do_sample(input logic [1:0] c, input logic [15:0] d);
      sv = 1'b1; sch = c; sdata = d;
      mid(); to_next();
      sv = 1'b0;
   endtask

   // Random traffic paced on instance k: EN only when that instance is idle or in its RDY cycle.
   task automatic rand_phase(input int k, input int ncyc);
      bit free;
      for (int i = 0; i < ncyc; i++) begin
         free  = !m_busy[k] || (m_due[k] == cyc);
         en    = free && ($urandom_range(0, 3) != 0);
         addr  = ADDRS[$urandom_range(0, 18)];
         we    = ($urandom_range(0, 4) == 0);
         di    = 16'($urandom);
         sv    = ($urandom_range(0, 1) == 1);
         sch   = 2'($urandom_range(0, 3));
         sdata = 16'($urandom);
         mid(); to_next();
      end
      en = 1'b0; we = 1'b0; sv = 1'b0;
      idle(20);
   endtask

   vec_t tbl [22];

   initial begin
      bit [7:0] pat_en;
      bit [7:0] pat_rdy;
      bit [7:0] pat_perr;

      total = 0; bad = 0; cyc = 0;
      rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = 8'h00; di = 16'h0000;
      sv = 1'b0; sch = 2'd0; sdata = 16'h0000;

      tbl[0]  = '{1, 8'h00, 0, 16'h1234, 16'h0000};
      tbl[1]  = '{0, 8'h00, 0, 16'h0000, 16'h1234};
      tbl[2]  = '{0, 8'h20, 0, 16'h0000, 16'h1234};
      tbl[3]  = '{0, 8'h24, 0, 16'h0000, 16'h1234};
      tbl[4]  = '{1, 8'h01, 0, 16'h0500, 16'h0000};
      tbl[5]  = '{1, 8'h01, 0, 16'h0300, 16'h0000};
      tbl[6]  = '{1, 8'h01, 0, 16'h0800, 16'h0000};
      tbl[7]  = '{0, 8'h01, 0, 16'h0000, 16'h0800};
      tbl[8]  = '{0, 8'h21, 0, 16'h0000, 16'h0800};
      tbl[9]  = '{0, 8'h25, 0, 16'h0000, 16'h0300};
      tbl[10] = '{0, 8'h03, 1, 16'h0001, 16'h0000};
      tbl[11] = '{0, 8'h21, 0, 16'h0000, 16'h0000};
      tbl[12] = '{0, 8'h25, 0, 16'h0000, 16'hFFFF};
      tbl[13] = '{0, 8'h01, 0, 16'h0000, 16'h0800};
      tbl[14] = '{0, 8'h41, 1, 16'hBEEF, 16'h0000};
      tbl[15] = '{0, 8'h41, 0, 16'h0000, 16'hBEEF};
      tbl[16] = '{0, 8'h00, 1, 16'hAAAA, 16'h0000};
      tbl[17] = '{0, 8'h00, 0, 16'h0000, 16'h1234};
      tbl[18] = '{0, 8'h10, 0, 16'h0000, 16'h0000};
      tbl[19] = '{1, 8'h02, 0, 16'h0777, 16'h0000};
      tbl[20] = '{0, 8'h03, 1, 16'h0002, 16'h0000};
      tbl[21] = '{0, 8'h26, 0, 16'h0000, 16'h0777};

      to_next();
      do_reset();

      // Directed register-map vectors.
      for (int i = 0; i < 22; i++) begin
         if (tbl[i].smp) do_sample(tbl[i].a[1:0], tbl[i].d);
         else            drp_op(tbl[i]);
      end

      // Reset one cycle after a write request: no RDY, no commit.
      do_reset();
      en = 1'b1; we = 1'b1; addr = 8'h40; di = 16'h5555;
      mid(); to_next();
      en = 1'b0; we = 1'b0; rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mid();
         chk("abort_rdy", 0, 32'(rdy_w[0]), 0);
         chk("abort_do", 0, 32'(do_w[0]), 0);
         to_next();
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mid();
         chk("no_late_rdy", 0, 32'(rdy_w[0]), 0);
         to_next();
      end
      drp_op('{0, 8'h40, 0, 16'h0000, 16'h0000});

      // Latency-3 instance: EN while busy, then EN in the RDY cycle.
      do_reset();
      pat_en   = 8'b0000_1011;
      pat_rdy  = 8'b0100_1000;
      pat_perr = 8'b1111_1100;
      for (int j = 0; j < 8; j++) begin
         en = pat_en[j]; we = 1'b0; addr = 8'h40 + 8'(j);
         mid();
         chk("b2b_rdy", 1, 32'(rdy_w[1]), 32'(pat_rdy[j]));
         chk("b2b_perr", 1, 32'(perr_w[1]), 32'(pat_perr[j]));
         to_next();
      end
      en = 1'b0;
      idle(20);

      // Randomized back-to-back traffic for the latency extremes, then unpaced traffic.
      do_reset();
      rand_phase(2, 600);
      do_reset();
      rand_phase(3, 2500);
      do_reset();
      rand_phase(0, 800);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
